line_mem_responder: RTL and testbench

//  Memory-side responder for the data-cache controller FSM: services line-fill (Load) and victim

---
 rtl/line_mem_responder.sv | 190 +++++++++++++++++++
 tb/tb_line_mem_responder.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/line_mem_responder.sv
// line_mem_responder
//   Memory-side responder for the data-cache controller. Services line-fill (Load) and victim
//   writeback requests against a word-organised backing RAM: a fixed access latency, then a
//   one-word-per-cycle burst, then a one-cycle RESP state carrying the done pulse(s).
//   A combined request always performs the writeback first, then the load.
//
// Ports
//   CLK        in   clock, all state on rising edge
//   RST        in   synchronous active-high reset
//   Load       in   line-fill request (level, sampled only in IDLE)
//   writeback  in   line-writeback request (level, sampled only in IDLE)
//   ld_addr    in   byte address of the line to fill
//   wb_addr    in   byte address of the line to write back
//   wb_line    in   victim line, word 0 in LSBs, held stable while busy
//   fill_line  out  filled line, word 0 in LSBs
//   busy       out  high in every state except IDLE
//   wb_done    out  one-cycle pulse: writeback committed
//   ld_done    out  one-cycle pulse: fill_line valid
//
// Configuration
//   LINE_MEM_RESP_FWD_EN  when defined, a combined request whose two addresses map to the same
//                         line forwards wb_line straight into fill_line at the end of the
//                         writeback burst and skips the load phase.

module line_mem_responder #(
    parameter int unsigned WORDS_PER_LINE = 4,
    parameter int unsigned DATA_W         = 32,
    parameter int unsigned ADDR_W         = 32,
    parameter int unsigned MEM_DEPTH      = 1024,
    parameter int unsigned LATENCY        = 3
) (
    input  logic                             CLK,
    input  logic                             RST,
    input  logic                             Load,
    input  logic                             writeback,
    input  logic [ADDR_W-1:0]                ld_addr,
    input  logic [ADDR_W-1:0]                wb_addr,
    input  logic [WORDS_PER_LINE*DATA_W-1:0] wb_line,
    output logic [WORDS_PER_LINE*DATA_W-1:0] fill_line,
    output logic                             busy,
    output logic                             wb_done,
    output logic                             ld_done
);

    localparam int unsigned OFF   = $clog2(WORDS_PER_LINE * DATA_W / 8);
    localparam int unsigned IDX_W = $clog2(MEM_DEPTH / WORDS_PER_LINE);
    localparam int unsigned K_W   = $clog2(WORDS_PER_LINE);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    localparam logic [K_W-1:0]   LAST_WORD = K_W'(WORDS_PER_LINE - 1);
    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(LATENCY - 1);

    typedef enum logic [2:0] {
        StIdle, StWbWait, StWbBurst, StLdWait, StLdBurst, StResp
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    wait_cnt;
    logic [K_W-1:0]      word_cnt;
    logic [IDX_W-1:0]    wb_idx;
    logic [IDX_W-1:0]    ld_idx;
    logic                pend_ld;
    logic                did_wb;

    logic [DATA_W-1:0]   mem [MEM_DEPTH];
    logic [DATA_W-1:0]   wb_words [WORDS_PER_LINE];
    logic [DATA_W-1:0]   rd_data;
    logic [IDX_W+K_W-1:0] wr_addr;
    logic [IDX_W+K_W-1:0] rd_addr;

    // Offset and upper address bits are deliberately ignored (upper bits alias).
    logic unused_addr_bits;
    assign unused_addr_bits = ^{ld_addr, wb_addr};

    always_comb begin
        for (int k = 0; k < WORDS_PER_LINE; k++) begin
            wb_words[k] = wb_line[k*DATA_W +: DATA_W];
        end
    end

    assign wr_addr = {wb_idx, word_cnt};
    assign rd_addr = {ld_idx, word_cnt};
    assign rd_data = mem[rd_addr];

    // Backing RAM is never reset; words written before a reset stay written.
    always_ff @(posedge CLK) begin
        if (!RST && state == StWbBurst) begin
            mem[wr_addr] <= wb_words[word_cnt];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= StIdle;
            wait_cnt  <= '0;
            word_cnt  <= '0;
            wb_idx    <= '0;
            ld_idx    <= '0;
            pend_ld   <= 1'b0;
            did_wb    <= 1'b0;
            busy      <= 1'b0;
            wb_done   <= 1'b0;
            ld_done   <= 1'b0;
            fill_line <= '0;
        end else begin
            wb_done <= 1'b0;
            ld_done <= 1'b0;
            case (state)
                StIdle: begin
                    word_cnt <= '0;
                    // The request-sampling cycle is the first latency cycle, so the wait
                    // state starts one count in.
                    wait_cnt <= CNT_W'(1);
                    ld_idx   <= ld_addr[OFF +: IDX_W];
                    if (writeback) begin
                        wb_idx  <= wb_addr[OFF +: IDX_W];
                        pend_ld <= Load;
                        did_wb  <= 1'b1;
                        busy    <= 1'b1;
                        state   <= (LATENCY == 1) ? StWbBurst : StWbWait;
                    end else if (Load) begin
                        pend_ld <= 1'b0;
                        did_wb  <= 1'b0;
                        busy    <= 1'b1;
                        state   <= (LATENCY == 1) ? StLdBurst : StLdWait;
                    end
                end
                StWbWait: begin
                    if (wait_cnt >= LAST_WAIT) begin
                        state    <= StWbBurst;
                        word_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                StWbBurst: begin
                    word_cnt <= word_cnt + K_W'(1);
                    if (word_cnt == LAST_WORD) begin
`ifdef LINE_MEM_RESP_FWD_EN
                        if (pend_ld && ld_idx == wb_idx) begin
                            fill_line <= wb_line;
                            wb_done   <= 1'b1;
                            ld_done   <= 1'b1;
                            state     <= StResp;
                        end else
`endif
                        if (pend_ld) begin
                            // Load phase waits the full latency from scratch.
                            wait_cnt <= '0;
                            state    <= StLdWait;
                        end else begin
                            wb_done <= 1'b1;
                            state   <= StResp;
                        end
                    end
                end
                StLdWait: begin
                    if (wait_cnt >= LAST_WAIT) begin
                        state    <= StLdBurst;
                        word_cnt <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end
                StLdBurst: begin
                    for (int k = 0; k < WORDS_PER_LINE; k++) begin
                        if (word_cnt == K_W'(k)) begin
                            fill_line[k*DATA_W +: DATA_W] <= rd_data;
                        end
                    end
                    word_cnt <= word_cnt + K_W'(1);
                    if (word_cnt == LAST_WORD) begin
                        wb_done <= did_wb;
                        ld_done <= 1'b1;
                        state   <= StResp;
                    end
                end
                StResp: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_line_mem_responder.sv
module tb_line_mem_responder;

    localparam int W          = 4;
    localparam int LAT        = 3;
    localparam int LINES      = 256;
    localparam int LINE_BYTES = 16;

    logic         CLK = 1'b0;
    logic         RST;
    logic         Load;
    logic         writeback;
    logic [31:0]  ld_addr;
    logic [31:0]  wb_addr;
    logic [127:0] wb_line;
    logic [127:0] fill_line;
    logic         busy;
    logic         wb_done;
    logic         ld_done;

    line_mem_responder dut (
        .CLK       (CLK),
        .RST       (RST),
        .Load      (Load),
        .writeback (writeback),
        .ld_addr   (ld_addr),
        .wb_addr   (wb_addr),
        .wb_line   (wb_line),
        .fill_line (fill_line),
        .busy      (busy),
        .wb_done   (wb_done),
        .ld_done   (ld_done)
    );

    always #5 CLK = ~CLK;

    int total = 0;
    int bad   = 0;

    // Model: line-granular memory plus the timing of the current operation.
    logic [127:0] mdl_mem [LINES];
    int           cyc = 0;
    int           base = 0;
    int           end_rel = 0;
    bit           op_active = 0;
    bit           done_ok = 0;
    bit           op_wb = 0;
    bit           op_ld = 0;
    bit           chk_en = 0;
    logic [127:0] fill_before = '0;
    logic [127:0] fill_after = '0;
    int           obs_busy_cnt = 0;
    int           obs_done_rel = 0;

    int           rel;
    bit           eb, ewd, eld;
    logic [127:0] ef;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int line_idx(input logic [31:0] a);
        return int'((a / LINE_BYTES) % LINES);
    endfunction

    always @(negedge CLK) begin
        cyc++;
        if (chk_en) begin
            rel = cyc - base;
            eb  = op_active && rel >= 1 && rel <= end_rel;
            ewd = op_active && done_ok && rel == end_rel && op_wb;
            eld = op_active && done_ok && rel == end_rel && op_ld;
            if (op_active && rel >= end_rel + (done_ok ? 0 : 1)) ef = fill_after;
            else ef = fill_before;
            chk("busy", {127'd0, busy}, {127'd0, eb});
            chk("wb_done", {127'd0, wb_done}, {127'd0, ewd});
            chk("ld_done", {127'd0, ld_done}, {127'd0, eld});
            if (!eb || ewd || eld) chk("fill_line", fill_line, ef);
            if (busy) obs_busy_cnt++;
            if (wb_done || ld_done) obs_done_rel = rel;
        end
    end

    // Issue one request at the start of a cycle (cycle 0 of the operation) and run it to
    // completion, or reset it in cycle abort_at when abort_at is nonzero.
    task automatic run_op(input bit do_wb, input bit do_ld, input logic [31:0] wa,
                          input logic [31:0] la, input logic [127:0] line, input int abort_at);
        int wi, li, resp;
        logic [127:0] nf;
        wi = line_idx(wa);
        li = line_idx(la);
        if (do_wb) mdl_mem[wi] = line;
        nf = do_ld ? mdl_mem[li] : fill_after;
        if (do_wb && do_ld) begin
`ifdef LINE_MEM_RESP_FWD_EN
            resp = (wi == li) ? (LAT + W) : 2 * (LAT + W);
`else
            resp = 2 * (LAT + W);
`endif
        end else begin
            resp = LAT + W;
        end
        fill_before  = fill_after;
        op_wb        = do_wb;
        op_ld        = do_ld;
        if (abort_at != 0) begin
            end_rel    = abort_at;
            done_ok    = 0;
            fill_after = '0;
        end else begin
            end_rel    = resp;
            done_ok    = 1;
            fill_after = nf;
        end
        obs_busy_cnt = 0;
        obs_done_rel = 0;
        base         = cyc + 1;
        op_active    = 1;
        writeback    = do_wb;
        Load         = do_ld;
        wb_addr      = wa;
        ld_addr      = la;
        wb_line      = line;
        if (abort_at != 0) begin
            repeat (abort_at) @(posedge CLK);
            #1;
            RST       = 1'b1;
            Load      = 1'b0;
            writeback = 1'b0;
            @(posedge CLK);
            #1;
            RST = 1'b0;
        end else begin
            // Requests stay asserted through the busy period; they must be ignored.
            repeat (end_rel) @(posedge CLK);
            #1;
            Load      = 1'b0;
            writeback = 1'b0;
        end
        repeat (2) @(posedge CLK);
        #1;
    endtask

    logic [127:0] la_line, lb_line, lc_line;

    initial begin
        la_line = {32'hA3, 32'hA2, 32'hA1, 32'hA0};
        lb_line = {32'hB3, 32'hB2, 32'hB1, 32'hB0};
        lc_line = {32'hC3, 32'hC2, 32'hC1, 32'hC0};
        for (int i = 0; i < LINES; i++) mdl_mem[i] = 'x;
        RST       = 1'b1;
        Load      = 1'b0;
        writeback = 1'b0;
        ld_addr   = '0;
        wb_addr   = '0;
        wb_line   = '0;
        repeat (2) @(posedge CLK);
        #1;
        RST = 1'b0;
        chk("reset busy", {127'd0, busy}, 128'd0);
        chk("reset wb_done", {127'd0, wb_done}, 128'd0);
        chk("reset ld_done", {127'd0, ld_done}, 128'd0);
        chk("reset fill_line", fill_line, 128'd0);
        chk_en = 1;

        run_op(1, 0, 32'h40, 32'h0, la_line, 0);
        chk("wb busy cycles", 128'(obs_busy_cnt), 128'd7);
        chk("wb done cycle", 128'(obs_done_rel), 128'd7);

        run_op(0, 1, 32'h0, 32'h40, '0, 0);
        chk("ld done cycle", 128'(obs_done_rel), 128'd7);
        chk("ld fill", fill_line, 128'h000000a3_000000a2_000000a1_000000a0);

        run_op(0, 1, 32'h0, 32'h4040, '0, 0);
        chk("alias fill", fill_line, 128'h000000a3_000000a2_000000a1_000000a0);

        run_op(1, 1, 32'h80, 32'h40, lc_line, 0);
        chk("combined done cycle", 128'(obs_done_rel), 128'd14);
        chk("combined fill", fill_line, 128'h000000a3_000000a2_000000a1_000000a0);

        run_op(1, 1, 32'hC0, 32'hC0, lb_line, 0);
`ifdef LINE_MEM_RESP_FWD_EN
        chk("same-line done cycle", 128'(obs_done_rel), 128'd7);
`else
        chk("same-line done cycle", 128'(obs_done_rel), 128'd14);
`endif
        chk("same-line fill", fill_line, 128'h000000b3_000000b2_000000b1_000000b0);

        run_op(0, 1, 32'h0, 32'h80, '0, 0);
        chk("readback 0x80", fill_line, 128'h000000c3_000000c2_000000c1_000000c0);

        run_op(0, 1, 32'h0, 32'h40, '0, 4);
        chk("abort fill", fill_line, 128'd0);
        chk("abort no done", 128'(obs_done_rel), 128'd0);
        chk("abort busy cycles", 128'(obs_busy_cnt), 128'd4);

        run_op(0, 1, 32'h0, 32'hC0, '0, 0);
        chk("readback 0xC0", fill_line, 128'h000000b3_000000b2_000000b1_000000b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
